// File: rtl/regfile_trace.sv
// Parametrised register file with combinational read ports, run-time
// selectable debug taps, and a show-ahead trace FIFO that records every
// effective register writeback for logging by a consumer.
module regfile_trace #(
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int NUM_RD      = 2,
    parameter int NUM_DBG     = 6,
    parameter int TRACE_DEPTH = 16,
    parameter int BYPASS      = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ctrl_writeEnable,
    input  logic [AW-1:0]                 ctrl_writeReg,
    input  logic [DW-1:0]                 data_writeReg,
    input  logic [NUM_RD*AW-1:0]          ctrl_readReg,
    output logic [NUM_RD*DW-1:0]          data_readReg,
    input  logic [NUM_DBG*AW-1:0]         dbg_sel,
    output logic [NUM_DBG*DW-1:0]         dbg_data,
    input  logic                          trace_en,
    input  logic                          trace_clear,
    output logic                          trace_valid,
    input  logic                          trace_ready,
    output logic [AW-1:0]                 trace_reg,
    output logic [DW-1:0]                 trace_data,
    output logic [$clog2(TRACE_DEPTH):0]  trace_count,
    output logic                          trace_overflow
);

    localparam int NREG = 2 ** AW;
    localparam int PW   = $clog2(TRACE_DEPTH);
    localparam int CW   = PW + 1;
    localparam int EW_W = AW + DW;

    // Register storage; entry 0 is reset to zero and never written.
    logic [DW-1:0] regs_reg [NREG];

    // A write to register 0 has no architectural effect and is never traced.
    logic eff_write;
    assign eff_write = ctrl_writeEnable && (ctrl_writeReg != '0);

    // Register file update on effective writes; async reset clears every entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (eff_write) begin
            regs_reg[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Read ports: zero for r0, optional same-cycle forwarding of the write data.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0] rd_addr;
            logic [DW-1:0] rd_val;
            assign rd_addr = ctrl_readReg[gi*AW +: AW];

            // Select stored value, forwarded write data, or zero.
            always_comb begin
                rd_val = regs_reg[rd_addr];
                if (rd_addr == '0) begin
                    rd_val = '0;
                end else if ((BYPASS != 0) && eff_write && (ctrl_writeReg == rd_addr)) begin
                    rd_val = data_writeReg;
                end
            end

            assign data_readReg[gi*DW +: DW] = rd_val;
        end

        // Debug taps always show stored state; r0 is held at zero in storage.
        for (gi = 0; gi < NUM_DBG; gi++) begin : g_dbg
            assign dbg_data[gi*DW +: DW] = regs_reg[dbg_sel[gi*AW +: AW]];
        end
    endgenerate

    // Trace FIFO state.
    logic [EW_W-1:0] mem_reg [TRACE_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            ovf_reg, ovf_next;
    logic            fifo_full, fifo_empty;
    logic            push, pop, push_accept, mem_we;
    logic [EW_W-1:0] head;

    assign fifo_full  = (count_reg == CW'(TRACE_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign push       = eff_write && trace_en;
    assign pop        = !fifo_empty && trace_ready;
    // When full, a push only fits if the head leaves on the same edge.
    assign push_accept = push && (!fifo_full || pop);

    // Next-state for pointers, occupancy and sticky overflow; clear wins over all.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        mem_we      = 1'b0;
        if (trace_clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            ovf_next    = 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
                mem_we      = 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            if (push_accept && !pop) begin
                count_next = count_reg + CW'(1);
            end else if (pop && !push_accept) begin
                count_next = count_reg - CW'(1);
            end
            if (push && !push_accept) begin
                ovf_next = 1'b1;
            end
        end
    end

    // FIFO control registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
        end
    end

    // Record storage; contents are don't-care until counted as occupied.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_reg[wr_ptr_reg] <= {ctrl_writeReg, data_writeReg};
        end
    end

    // Show-ahead head, forced to zero while the FIFO is empty.
    always_comb begin
        head = mem_reg[rd_ptr_reg];
        if (fifo_empty) begin
            head = '0;
        end
    end

    assign trace_valid    = !fifo_empty;
    assign trace_reg      = head[EW_W-1:DW];
    assign trace_data     = head[DW-1:0];
    assign trace_count    = count_reg;
    assign trace_overflow = ovf_reg;

endmodule

// File: tb/tb_regfile_trace.sv
// Directed and randomized bench for regfile_trace, checked against a
// queue-based reference model of the register file and trace FIFO.
module tb_regfile_trace;

    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int NRD    = 2;
    localparam int NDBG   = 6;
    localparam int DEPTH  = 16;
    localparam int BYPASS = 1;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic                 clock;
    logic                 reset;
    logic                 ctrl_writeEnable;
    logic [AW-1:0]        ctrl_writeReg;
    logic [DW-1:0]        data_writeReg;
    logic [NRD*AW-1:0]    ctrl_readReg;
    logic [NRD*DW-1:0]    data_readReg;
    logic [NDBG*AW-1:0]   dbg_sel;
    logic [NDBG*DW-1:0]   dbg_data;
    logic                 trace_en;
    logic                 trace_clear;
    logic                 trace_valid;
    logic                 trace_ready;
    logic [AW-1:0]        trace_reg;
    logic [DW-1:0]        trace_data;
    logic [CW-1:0]        trace_count;
    logic                 trace_overflow;

    regfile_trace #(
        .DW(DW), .AW(AW), .NUM_RD(NRD), .NUM_DBG(NDBG),
        .TRACE_DEPTH(DEPTH), .BYPASS(BYPASS)
    ) dut (
        .clock(clock), .reset(reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .ctrl_readReg(ctrl_readReg),
        .data_readReg(data_readReg), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .trace_en(trace_en), .trace_clear(trace_clear), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_reg(trace_reg), .trace_data(trace_data),
        .trace_count(trace_count), .trace_overflow(trace_overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: architectural registers, record queue, sticky flag.
    logic [DW-1:0]    mregs [2**AW];
    logic [AW+DW-1:0] q [$];
    logic             movf;
    int               checks;
    int               errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2**AW; i++) mregs[i] = '0;
        q.delete();
        movf = 1'b0;
    endtask

    task automatic check_trace();
        logic [AW+DW-1:0] h;
        h = (q.size() != 0) ? q[0] : '0;
        chk("count", 64'(trace_count), 64'(q.size()));
        chk("valid", 64'(trace_valid), 64'(q.size() != 0));
        chk("head_reg", 64'(trace_reg), 64'(h[AW+DW-1:DW]));
        chk("head_data", 64'(trace_data), 64'(h[DW-1:0]));
        chk("overflow", 64'(trace_overflow), 64'(movf));
    endtask

    // One clock: check combinational outputs, advance model at the edge, check state.
    task automatic cycle();
        logic          ew, push, pop;
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        #1;
        ew = ctrl_writeEnable && (ctrl_writeReg != 0);
        for (int i = 0; i < NRD; i++) begin
            a = ctrl_readReg[i*AW +: AW];
            if (a == 0) e = '0;
            else if (BYPASS != 0 && ew && !reset && ctrl_writeReg == a) e = data_writeReg;
            else e = mregs[a];
            chk("read_port", 64'(data_readReg[i*DW +: DW]), 64'(e));
        end
        for (int i = 0; i < NDBG; i++) begin
            a = dbg_sel[i*AW +: AW];
            chk("dbg_tap", 64'(dbg_data[i*DW +: DW]), 64'(mregs[a]));
        end
        push = ew && trace_en;
        pop  = (q.size() != 0) && trace_ready;
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            if (ew) mregs[ctrl_writeReg] = data_writeReg;
            if (trace_clear) begin
                q.delete();
                movf = 1'b0;
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    if (q.size() < DEPTH) q.push_back({ctrl_writeReg, data_writeReg});
                    else movf = 1'b1;
                end
            end
        end
        #1;
        check_trace();
    endtask

    task automatic idle_inputs();
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_readReg     = '0;
        dbg_sel          = '0;
        trace_en         = 1'b1;
        trace_clear      = 1'b0;
        trace_ready      = 1'b0;
    endtask

    task automatic wr(input int r, input logic [DW-1:0] d);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = AW'(r);
        data_writeReg    = d;
        cycle();
        ctrl_writeEnable = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        idle_inputs();

        // Reset sanity: a write during reset has no effect.
        reset = 1'b1;
        for (int i = 0; i < NDBG; i++) dbg_sel[i*AW +: AW] = AW'(3);
        wr(3, 32'h1234);
        chk("rst_tap0", 64'(dbg_data[DW-1:0]), 64'h0);
        chk("rst_count", 64'(trace_count), 64'h0);
        reset = 1'b0;

        // Bypass read sees same-cycle data; tap only after the edge.
        trace_en = 1'b0;
        ctrl_readReg[0 +: AW] = AW'(3);
        dbg_sel[0 +: AW] = AW'(3);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = AW'(3); data_writeReg = 32'h1234;
        #1;
        chk("bypass_rd0", 64'(data_readReg[DW-1:0]), 64'h1234);
        chk("tap_before_edge", 64'(dbg_data[DW-1:0]), 64'h0);
        cycle();
        ctrl_writeEnable = 1'b0;
        chk("tap_after_edge", 64'(dbg_data[DW-1:0]), 64'h1234);

        // Register 0 writes are discarded and untraced.
        trace_en = 1'b1;
        ctrl_readReg = '0;
        dbg_sel = '0;
        wr(0, 32'hFFFF_FFFF);
        chk("r0_rd", 64'(data_readReg[DW-1:0]), 64'h0);
        chk("r0_count", 64'(trace_count), 64'h0);

        // Trace order with stalled consumer, then drain.
        trace_ready = 1'b0;
        wr(1, 32'hA); wr(2, 32'hB); wr(5, 32'hC);
        chk("order_count", 64'(trace_count), 64'd3);
        trace_ready = 1'b1;
        chk("order_h0", 64'({trace_reg, trace_data}), 64'({5'd1, 32'hA}));
        cycle();
        chk("order_h1", 64'({trace_reg, trace_data}), 64'({5'd2, 32'hB}));
        cycle();
        chk("order_h2", 64'({trace_reg, trace_data}), 64'({5'd5, 32'hC}));
        cycle();
        chk("order_empty", 64'({trace_valid, trace_count}), 64'h0);

        // Overflow: 17 pushes into 16 entries.
        trace_ready = 1'b0;
        for (int i = 1; i <= 17; i++) wr(i, DW'(i));
        chk("ovf_count", 64'(trace_count), 64'd16);
        chk("ovf_flag", 64'(trace_overflow), 64'h1);
        trace_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("ovf_drain", 64'({trace_reg, trace_data}), 64'({AW'(i), DW'(i)}));
            cycle();
        end
        chk("ovf_sticky", 64'(trace_overflow), 64'h1);

        // Full with simultaneous pop accepts the push.
        trace_clear = 1'b1; cycle(); trace_clear = 1'b0;
        trace_ready = 1'b0;
        for (int i = 1; i <= 16; i++) wr(i, DW'(i + 32'h100));
        trace_ready = 1'b1;
        wr(9, 32'h99);
        chk("fullpop_count", 64'(trace_count), 64'd16);
        chk("fullpop_ovf", 64'(trace_overflow), 64'h0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("fullpop_last", 64'({trace_reg, trace_data}), 64'({5'd9, 32'h99}));
            cycle();
        end

        // Clear priority over a same-cycle write.
        trace_ready = 1'b0;
        for (int i = 1; i <= 5; i++) wr(i + 10, DW'(i));
        trace_clear = 1'b1; trace_ready = 1'b1;
        wr(4, 32'h44);
        trace_clear = 1'b0;
        chk("clr_count", 64'(trace_count), 64'h0);
        chk("clr_ovf", 64'(trace_overflow), 64'h0);
        ctrl_readReg[AW +: AW] = AW'(4);
        #1;
        chk("clr_r4", 64'(data_readReg[DW +: DW]), 64'h44);
        cycle();

        // Asynchronous reset between edges.
        trace_ready = 1'b0;
        wr(1, 32'h11); wr(2, 32'h22); wr(3, 32'h33);
        dbg_sel[0 +: AW] = AW'(1);
        reset = 1'b1;
        #1;
        chk("async_count", 64'(trace_count), 64'h0);
        chk("async_valid", 64'(trace_valid), 64'h0);
        chk("async_tap", 64'(dbg_data[DW-1:0]), 64'h0);
        model_reset();
        #1 reset = 1'b0;

        // Wrap-around with continuous draining.
        trace_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr(1 + (i % 31), $urandom);
            chk("wrap_le1", 64'(trace_count <= 1), 64'h1);
        end

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            ctrl_writeEnable = ($urandom_range(3) != 0);
            ctrl_writeReg    = AW'($urandom);
            data_writeReg    = $urandom;
            trace_en         = ($urandom_range(9) != 0);
            trace_ready      = $urandom_range(1);
            trace_clear      = ($urandom_range(31) == 0);
            ctrl_readReg     = NRD*AW'($urandom);
            for (int i = 0; i < NDBG; i++) dbg_sel[i*AW +: AW] = AW'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
